// File: rtl/alu_arbiter_seq.sv
// Round-robin front end that shares one structural ALU between two requesters: it holds the
// operands for a fixed settle window, then captures the result and flags for the consumer.
module alu_arbiter_seq #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_cmd,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_cmd,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carryout,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic [WIDTH-1:0] alu_operandA,
  output logic [WIDTH-1:0] alu_operandB,
  output logic [2:0]       alu_command,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_grant_q, last_grant_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [2:0]         alu_cmd_q, alu_cmd_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
  logic               rsp_carry_q, rsp_carry_d;
  logic               rsp_zero_q, rsp_zero_d;
  logic               rsp_ovf_q, rsp_ovf_d;
  logic               busy_q, busy_d;

  logic               grant;
  logic               accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cmd_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_cmd_q    <= alu_cmd_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ovf_q    <= rsp_ovf_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_cmd_d    = alu_cmd_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ovf_d    = rsp_ovf_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          alu_a_d      = grant ? req1_a : req0_a;
          alu_b_d      = grant ? req1_b : req0_b;
          alu_cmd_d    = grant ? req1_cmd : req0_cmd;
          rsp_id_d     = grant;
          last_grant_d = grant;
          cnt_d        = CNT_W'(SETTLE_CYCLES - 1);
          state_d      = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // Operands stay frozen here so the ripple carry has the whole window to settle.
        if (cnt_q == '0) begin
          rsp_result_d = alu_result;
          rsp_carry_d  = alu_carryout;
          rsp_zero_d   = alu_zero;
          rsp_ovf_d    = alu_overflow;
          rsp_valid_d  = 1'b1;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Grant logic: a lone requester always wins; a tie goes to whoever did not win last.
  always_comb begin
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end else begin
      grant = ~last_grant_q;
    end
    req0_ready = rst_n && (state_q == S_IDLE) && req0_valid && !grant;
    req1_ready = rst_n && (state_q == S_IDLE) && req1_valid && grant;
    accept     = req0_ready || req1_ready;
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_carryout = rsp_carry_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_overflow = rsp_ovf_q;
  assign alu_operandA = alu_a_q;
  assign alu_operandB = alu_b_q;
  assign alu_command  = alu_cmd_q;
  assign busy         = busy_q;

endmodule
